// File: rtl/fp_int_converter.sv
// fp_int_converter: multi-cycle converter between signed int32 and IEEE-754
// single precision. Mode 0 normalises one bit per cycle and rounds to nearest
// even. Mode 1 aligns one bit per cycle and truncates toward zero. Results
// and flags are registered and held until the next conversion completes.
module fp_int_converter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] operand,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        inexact,
  output logic        overflow,
  output logic        invalid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ALIGN = 2'd2,
    PACK  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        mode_r, mode_s;
  logic        sign_r, sign_s;
  logic [31:0] mag_r, mag_s;
  logic [7:0]  exp_r, exp_s;
  logic [4:0]  cnt_r, cnt_s;
  logic        sticky_r, sticky_s;
  // Special cases are resolved at capture time and simply replayed at PACK.
  logic        spc_r, spc_s;
  logic [31:0] spc_res_r, spc_res_s;
  logic        spc_inx_r, spc_inx_s;
  logic        spc_ovf_r, spc_ovf_s;
  logic        spc_inv_r, spc_inv_s;

  logic        done_s;
  logic [31:0] result_s;
  logic        inexact_s, overflow_s, invalid_s;

  logic        round_inc_s;
  logic [23:0] mant_sum_s;
  logic [7:0]  pack_exp_s;

  // Next-state, datapath and output computation for the conversion FSM.
  always_comb begin
    state_s    = state_r;
    mode_s     = mode_r;
    sign_s     = sign_r;
    mag_s      = mag_r;
    exp_s      = exp_r;
    cnt_s      = cnt_r;
    sticky_s   = sticky_r;
    spc_s      = spc_r;
    spc_res_s  = spc_res_r;
    spc_inx_s  = spc_inx_r;
    spc_ovf_s  = spc_ovf_r;
    spc_inv_s  = spc_inv_r;
    done_s     = 1'b0;
    result_s   = result;
    inexact_s  = inexact;
    overflow_s = overflow;
    invalid_s  = invalid;

    // Round-nearest-even on the normalised magnitude; a carry out of the
    // 23-bit mantissa bumps the exponent and leaves a zero mantissa.
    round_inc_s = mag_r[7] & ((|mag_r[6:0]) | mag_r[8]);
    mant_sum_s  = {1'b0, mag_r[30:8]} + {23'd0, round_inc_s};
    pack_exp_s  = mant_sum_s[23] ? (exp_r + 8'd1) : exp_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          mode_s    = mode;
          sign_s    = operand[31];
          cnt_s     = 5'd0;
          sticky_s  = 1'b0;
          spc_s     = 1'b0;
          spc_res_s = 32'd0;
          spc_inx_s = 1'b0;
          spc_ovf_s = 1'b0;
          spc_inv_s = 1'b0;
          if (mode == 1'b0) begin
            // Two's-complement magnitude; 0x80000000 maps onto itself.
            mag_s = operand[31] ? (~operand + 32'd1) : operand;
            exp_s = 8'd158;
            if (operand == 32'd0) begin
              spc_s   = 1'b1;
              state_s = PACK;
            end else begin
              state_s = NORM;
            end
          end else begin
            mag_s = {1'b1, operand[22:0], 8'd0};
            exp_s = operand[30:23];
            // 158 - e fits in 1..31 for normal operands, so 5-bit modular
            // arithmetic (158 mod 32 = 30) yields the exact shift count.
            cnt_s = 5'd30 - operand[27:23];
            if (operand[30:23] == 8'd255) begin
              spc_s     = 1'b1;
              spc_res_s = 32'h7FFF_FFFF;
              spc_inv_s = 1'b1;
              state_s   = PACK;
            end else if (operand[30:23] < 8'd127) begin
              spc_s     = 1'b1;
              spc_inx_s = |operand[30:0];
              state_s   = PACK;
            end else if (operand[30:23] >= 8'd158) begin
              spc_s = 1'b1;
              if (operand == 32'hCF00_0000) begin
                spc_res_s = 32'h8000_0000;
              end else begin
                spc_res_s = 32'h7FFF_FFFF;
                spc_ovf_s = 1'b1;
                spc_inv_s = 1'b1;
              end
              state_s = PACK;
            end else begin
              state_s = ALIGN;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end

      NORM: begin
        if (mag_r[31]) begin
          state_s = PACK;
        end else begin
          mag_s = {mag_r[30:0], 1'b0};
          exp_s = exp_r - 8'd1;
        end
      end

      ALIGN: begin
        mag_s    = {1'b0, mag_r[31:1]};
        sticky_s = sticky_r | mag_r[0];
        cnt_s    = cnt_r - 5'd1;
        if (cnt_r == 5'd1) begin
          state_s = PACK;
        end else begin
          state_s = ALIGN;
        end
      end

      PACK: begin
        done_s     = 1'b1;
        state_s    = IDLE;
        overflow_s = 1'b0;
        invalid_s  = 1'b0;
        if (spc_r) begin
          result_s   = spc_res_r;
          inexact_s  = spc_inx_r;
          overflow_s = spc_ovf_r;
          invalid_s  = spc_inv_r;
        end else if (mode_r == 1'b0) begin
          result_s  = {sign_r, pack_exp_s, mant_sum_s[22:0]};
          inexact_s = |mag_r[7:0];
        end else begin
          result_s  = sign_r ? (~mag_r + 32'd1) : mag_r;
          inexact_s = sticky_r;
        end
      end

      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset aborts any conversion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      mode_r    <= 1'b0;
      sign_r    <= 1'b0;
      mag_r     <= 32'd0;
      exp_r     <= 8'd0;
      cnt_r     <= 5'd0;
      sticky_r  <= 1'b0;
      spc_r     <= 1'b0;
      spc_res_r <= 32'd0;
      spc_inx_r <= 1'b0;
      spc_ovf_r <= 1'b0;
      spc_inv_r <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 32'd0;
      inexact   <= 1'b0;
      overflow  <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      state_r   <= state_s;
      mode_r    <= mode_s;
      sign_r    <= sign_s;
      mag_r     <= mag_s;
      exp_r     <= exp_s;
      cnt_r     <= cnt_s;
      sticky_r  <= sticky_s;
      spc_r     <= spc_s;
      spc_res_r <= spc_res_s;
      spc_inx_r <= spc_inx_s;
      spc_ovf_r <= spc_ovf_s;
      spc_inv_r <= spc_inv_s;
      busy      <= (state_s != IDLE);
      done      <= done_s;
      result    <= result_s;
      inexact   <= inexact_s;
      overflow  <= overflow_s;
      invalid   <= invalid_s;
    end
  end

endmodule

// File: doc/fp_int_converter.md
FP_INT_CONVERTER -- requirements
Module: fp_int_converter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit single precision.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 mode  input  1  0 = signed int32 to float (cvt.s.w); 1 = float to int32, truncate toward zero (trunc.w.s).
REQ-006 operand  input  32  source word; captured on the accepted start edge.
REQ-007 busy  output  1  high while a conversion is in progress (state != IDLE).
REQ-008 done  output  1  registered, single-cycle pulse; result and flags valid from this cycle.
REQ-009 result  output  32  converted word.
REQ-010 inexact  output  1  nonzero bits discarded by rounding or truncation.
REQ-011 overflow  output  1  float magnitude not representable in int32.
REQ-012 invalid  output  1  NaN/Inf source, or overflow, in mode 1.

Function
REQ-013 The FSM SHALL have states IDLE, NORM, ALIGN and PACK; cycle 0 is the cycle in which start is sampled high in IDLE.
REQ-014 A start seen outside IDLE SHALL be ignored, with no effect on operand capture, state or outputs.
REQ-015 mode 0 capture: sign = operand[31], 32-bit mag = |operand| (0x80000000 yields mag 0x80000000), exp = 158; the next state SHALL be NORM, or PACK when mag = 0.
REQ-016 NORM: if mag[31] = 1, go to PACK; otherwise shift mag left 1 and decrement exp, one bit per cycle.
REQ-017 mode 0 PACK: mantissa = mag[30:8], guard = mag[7], sticky = |mag[6:0]; increment when guard & (sticky | mag[8]) (round-nearest-even); a mantissa carry-out SHALL zero the mantissa and increment exp; inexact = |mag[7:0]; zero input SHALL give result 0x00000000.
REQ-018 mode 1 capture: e = operand[30:23]; special cases SHALL go directly to PACK:
  - e = 255: result 0x7FFFFFFF, invalid = 1.
  - e < 127: result 0, inexact = |operand[30:0].
  - e >= 158: result 0x80000000 when operand = 0xCF000000 exactly, else 0x7FFFFFFF with overflow = 1 and invalid = 1.
REQ-019 mode 1 otherwise: mag = {1, operand[22:0], 8'b0}, shift count s = 158 - e (1..31), next state ALIGN.
REQ-020 ALIGN: shift mag right 1 per cycle, OR each shifted-out bit into sticky, decrement the counter; go to PACK after s shifts.
REQ-021 mode 1 PACK: result = sign ? -mag : mag; inexact = sticky.
REQ-022 PACK SHALL register result and flags, set done = 1 for exactly one cycle and return to IDLE; a start may be accepted in the done cycle.
REQ-023 Latency SHALL be as follows:
  - mode 0 nonzero: done in cycle n+3, n = leading zeros of mag.
  - mode 0 zero and all mode 1 special cases: done in cycle 2.
  - mode 1 normal: done in cycle s+2.
REQ-024 busy SHALL be high from cycle 1 through the PACK cycle inclusive.
REQ-025 result and all flags SHALL hold their values until the next PACK writes them.
REQ-026 Flags not named for a case SHALL be written 0 at PACK.

Reset
REQ-027 reset SHALL force IDLE and clear busy, done, result, inexact, overflow and invalid to 0, overriding any simultaneous start.
REQ-028 reset asserted mid-conversion SHALL abort it with no done pulse; the first start after reset is released SHALL be accepted normally.

Verification
REQ-029 mode 0, operand 0xFFFFFFFB (-5) -> result 0xC0A00000, flags 0, done in cycle 32, busy cycles 1-31.
REQ-030 mode 0, operand 0x01000001 -> result 0x4B800000, inexact 1, done in cycle 10; operand 0 -> 0x00000000, done in cycle 2.
REQ-031 mode 1 cases:
  - 0x40600000 (3.5) -> result 3, inexact 1, done in cycle 32.
  - 0xC0400000 (-3.0) -> 0xFFFFFFFD, inexact 0.
  - 0x3F000000 (0.5) -> 0, inexact 1, done in cycle 2.
REQ-032 mode 1 cases:
  - 0x7FC00000 (NaN) -> 0x7FFFFFFF, invalid 1.
  - 0x4F000000 (2^31) -> 0x7FFFFFFF, overflow 1, invalid 1.
  - 0xCF000000 -> 0x80000000, flags 0.
REQ-033 Second start pulsed in cycle 5 of a mode 0 conversion of 1 -> ignored; single done in cycle 34 with result 0x3F800000.
REQ-034 reset asserted in cycle 10 of a mode 0 conversion of 1 -> next cycle idle, no done, all outputs 0; a new start is then accepted normally.
